pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the PC write enable and the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch and jump squashes, and multi-cycle data-memory waits.
- Keeps a saturating stall-cycle performance counter.

Parameters:
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on rising edge of clk
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  instruction in EX is a load
ex_wr_reg  in  5  destination register of instruction in EX
ex_branch_taken  in  1  branch resolved taken in EX
id_jump  in  1  jump decoded in ID
mem_req  in  1  MEM-stage access in progress
mem_ready  in  1  data memory completes access this cycle
pc_we  out  1  PC register write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID load NOP
idex_we  out  1  ID/EX write enable
idex_flush  out  1  ID/EX load bubble (all control fields 0)
exmem_we  out  1  EX/MEM write enable
memwb_bubble  out  1  MEM/WB load bubble (RegWr=0)
stall_cnt  out  CNT_W  cycles with pc_we=0 since reset

Behaviour:
- Outputs are combinational from state plus inputs (Mealy), so a stall takes effect in the cycle the hazard is present. stall_cnt and state are registered.
- While reset=1:
  - Enable outputs: pc_we, ifid_we, idex_we, exmem_we = 0.
  - Flush and bubble outputs: ifid_flush, idex_flush, memwb_bubble = 0.
  - Registered state: stall_cnt=0, state=RUN, lu_cnt=0, ret_state=RUN.
- load_use = ex_memread && ex_wr_reg!=0 && (ex_wr_reg==id_rs || (id_uses_rt && ex_wr_reg==id_rt)). Register $0 never hazards.
- Default outputs, outside reset: all *_we=1, flush/bubble=0.
- States are RUN, LU_STALL and MEM_WAIT.
- freeze = mem_req && !mem_ready. Freeze has top priority in every state:
  - all *_we=0, memwb_bubble=1, flushes=0.
  - The current state is saved to ret_state and the next state is MEM_WAIT. lu_cnt is held.
- MEM_WAIT:
  - Freeze outputs are held while !mem_ready.
  - In the cycle mem_ready=1, outputs are evaluated exactly as in ret_state with the freeze condition cleared.
  - The next state follows from that evaluation.
- RUN priority, after freeze:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1. Load-use and jump are ignored because the ID instruction is squashed.
  2. load_use: pc_we=0, ifid_we=0, idex_flush=1. If LOAD_USE_CYCLES>1, go to LU_STALL with lu_cnt=LOAD_USE_CYCLES-1.
  3. id_jump: ifid_flush=1.
- LU_STALL:
  - Outputs are the same as the load_use outputs above.
  - lu_cnt decrements each cycle; when lu_cnt==1, go to RUN.
  - ex_branch_taken cannot occur here because EX holds a bubble. If it is asserted anyway, branch handling as in RUN wins and the next state is RUN.
- stall_cnt increments every cycle with pc_we=0 (freeze or load-use) and saturates at 2^CNT_W-1. It does not count while reset=1.
- Reset mid-freeze or mid-LU_STALL: state returns to RUN next edge; no pending stall survives.
- Simultaneous mem_ready and new load_use in the release cycle: load-use stall is applied in that same cycle.

Decomposition:
- Shared header pipe_ctrl_defs holds the state encodings (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2) and the $0 register constant.
- One sub-module, hazard_detect, is the purely combinational load_use comparator. The FSM, counters and output mux stay in the top.

Test Plan:
- Load-use: EX lw $8, ID add $9,$8,$1 (id_rs=8) -> one cycle of pc_we=0, ifid_we=0, idex_flush=1; stall_cnt 0->1; next cycle all we=1.
- $0 and rt gating:
  - ex_wr_reg=0 with id_rs=0 -> no stall.
  - id_rt matches but id_uses_rt=0 -> no stall.
- Branch beats load-use: ex_branch_taken=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_we=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 3 cycles of all we=0 and memwb_bubble=1, stall_cnt+=3, release cycle all we=1.
- LOAD_USE_CYCLES=3 with a freeze injected in the 2nd stall cycle:
  - stall lasts 3 non-frozen cycles plus the freeze cycles.
  - lu_cnt is held during the freeze.
  - Exit to RUN follows.
- Reset asserted during MEM_WAIT -> next edge: outputs at reset values, stall_cnt=0. After reset is released, the FSM is in RUN with all we=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings and the hard-wired zero register number.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in EX and the
// source operands of the instruction in ID.
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       ex_memread_i,
   input  logic [4:0] ex_wr_reg_i,
   output logic       load_use_o
);

   always_comb begin
      load_use_o = ex_memread_i && (ex_wr_reg_i != REG_ZERO) &&
                   ((ex_wr_reg_i == id_rs_i) ||
                    (id_uses_rt_i && (ex_wr_reg_i == id_rt_i)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch/jump squashes, data-memory waits and a stall-cycle counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_wr_reg,
   input  logic             ex_branch_taken,
   input  logic             id_jump,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e           state_q, state_d;
   state_e           ret_q, ret_d;
   state_e           eval_st;
   logic [2:0]       lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             load_use;
   logic             frozen;

   hazard_detect u_hazard_detect (
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .id_uses_rt_i (id_uses_rt),
      .ex_memread_i (ex_memread),
      .ex_wr_reg_i  (ex_wr_reg),
      .load_use_o   (load_use)
   );

   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_we      = 1'b1;
      idex_flush   = 1'b0;
      exmem_we     = 1'b1;
      memwb_bubble = 1'b0;
      state_d      = state_q;
      ret_d        = ret_q;
      lu_cnt_d     = lu_cnt_q;

      // On release from MEM_WAIT, behave exactly as the interrupted state.
      eval_st = (state_q == MEM_WAIT) ? ret_q : state_q;
      frozen  = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

      if (reset) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
      end else if (frozen) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         memwb_bubble = 1'b1;
         if (state_q != MEM_WAIT) ret_d = state_q;
         state_d = MEM_WAIT;
      end else begin
         state_d = RUN;
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (eval_st == LU_STALL) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            lu_cnt_d   = 3'(lu_cnt_q - 3'd1);
            if (lu_cnt_q != 3'd1) state_d = LU_STALL;
         end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
               state_d  = LU_STALL;
               lu_cnt_d = 3'(LOAD_USE_CYCLES - 1);
            end
         end else if (id_jump) begin
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         ret_q       <= RUN;
         lu_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         lu_cnt_q <= lu_cnt_d;
         if (!pc_we && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus one with
// three load-use bubbles and a narrow counter to exercise saturation.
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] O_RUN = 7'b1101010; // {pc,ifid_we,ifid_fl,idex_we,idex_fl,exmem_we,bubble}
   localparam logic [6:0] O_LU  = 7'b0001110;
   localparam logic [6:0] O_BR  = 7'b1111110;
   localparam logic [6:0] O_JMP = 7'b1111010;
   localparam logic [6:0] O_FRZ = 7'b0000001;
   localparam logic [6:0] O_RST = 7'b0000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_wr_reg;
   logic        id_uses_rt, ex_memread, ex_branch_taken, id_jump, mem_req, mem_ready;
   logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble;
   logic        pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_flush3, exmem_we3, memwb_bubble3;
   logic [31:0] stall_cnt;
   logic [2:0]  stall_cnt3;
   logic [6:0]  outs, outs3;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   assign outs  = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble};
   assign outs3 = {pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_flush3, exmem_we3, memwb_bubble3};

   pipeline_hazard_ctrl u_dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_wr_reg(ex_wr_reg), .ex_branch_taken(ex_branch_taken),
      .id_jump(id_jump), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
      .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
      .stall_cnt(stall_cnt)
   );

   pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(3)) u_dut3 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_wr_reg(ex_wr_reg), .ex_branch_taken(ex_branch_taken),
      .id_jump(id_jump), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we3), .ifid_we(ifid_we3), .ifid_flush(ifid_flush3), .idex_we(idex_we3),
      .idex_flush(idex_flush3), .exmem_we(exmem_we3), .memwb_bubble(memwb_bubble3),
      .stall_cnt(stall_cnt3)
   );

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mrd, input logic [4:0] wr, input logic br,
                        input logic jmp, input logic req, input logic rdy);
      id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mrd; ex_wr_reg = wr;
      ex_branch_taken = br; id_jump = jmp; mem_req = req; mem_ready = rdy;
      #1;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (outs !== O_RST) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
      tick();
      tick();
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
      reset = 1'b0;
      idle();
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL reset_release: got %b want %b", outs, O_RUN); end
      tick();
   endtask

   task automatic test_load_use();
      pulse_reset();
      drive(5'd8, 5'd1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lu_outs: got %b want %b", outs, O_LU); end
      tick();
      checks++;
      if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
      idle();
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL lu_after: got %b want %b", outs, O_RUN); end
      tick();
   endtask

   task automatic test_gating();
      pulse_reset();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL gate_r0: got %b want %b", outs, O_RUN); end
      drive(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL gate_rt_unused: got %b want %b", outs, O_RUN); end
      drive(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL gate_rt_used: got %b want %b", outs, O_LU); end
      tick();
      checks++;
      if (stall_cnt !== 32'd1) begin errors++; $display("FAIL gate_cnt: got %0d want 1", stall_cnt); end
   endtask

   task automatic test_branch_priority();
      pulse_reset();
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== O_BR) begin errors++; $display("FAIL br_outs: got %b want %b", outs, O_BR); end
      tick();
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL br_cnt: got %0d want 0", stall_cnt); end
      drive(5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== O_JMP) begin errors++; $display("FAIL jmp_outs: got %b want %b", outs, O_JMP); end
      drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL lu_over_jmp: got %b want %b", outs, O_LU); end
      tick();
      checks++;
      if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_over_jmp_cnt: got %0d want 1", stall_cnt); end
   endtask

   task automatic test_mem_wait();
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         checks++;
         if (outs !== O_FRZ) begin errors++; $display("FAIL frz_outs[%0d]: got %b want %b", i, outs, O_FRZ); end
         tick();
      end
      checks++;
      if (stall_cnt !== 32'd3) begin errors++; $display("FAIL frz_cnt: got %0d want 3", stall_cnt); end
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL frz_release: got %b want %b", outs, O_RUN); end
      tick();
      checks++;
      if (stall_cnt !== 32'd3) begin errors++; $display("FAIL frz_release_cnt: got %0d want 3", stall_cnt); end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== O_LU) begin errors++; $display("FAIL release_lu: got %b want %b", outs, O_LU); end
      tick();
      checks++;
      if (stall_cnt !== 32'd2) begin errors++; $display("FAIL release_lu_cnt: got %0d want 2", stall_cnt); end
      idle();
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL release_lu_after: got %b want %b", outs, O_RUN); end
      tick();
   endtask

   task automatic test_lu3_freeze();
      logic [6:0] exp3 [5];
      logic [2:0] expc [5];
      exp3 = '{O_LU, O_FRZ, O_LU, O_LU, O_RUN};
      expc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            1:       drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            2:       drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            default: idle();
         endcase
         checks++;
         if (outs3 !== exp3[i]) begin errors++; $display("FAIL lu3_outs[%0d]: got %b want %b", i, outs3, exp3[i]); end
         tick();
         checks++;
         if (stall_cnt3 !== expc[i]) begin errors++; $display("FAIL lu3_cnt[%0d]: got %0d want %0d", i, stall_cnt3, expc[i]); end
      end
   endtask

   task automatic test_saturation();
      pulse_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (9) tick();
      checks++;
      if (stall_cnt3 !== 3'd7) begin errors++; $display("FAIL sat_cnt3: got %0d want 7", stall_cnt3); end
      checks++;
      if (stall_cnt !== 32'd9) begin errors++; $display("FAIL sat_cnt32: got %0d want 9", stall_cnt); end
   endtask

   task automatic test_reset_midwait();
      pulse_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (outs !== O_RST) begin errors++; $display("FAIL rst_wait_outs: got %b want %b", outs, O_RST); end
      tick();
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_wait_cnt: got %0d want 0", stall_cnt); end
      reset = 1'b0;
      idle();
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL rst_wait_run: got %b want %b", outs, O_RUN); end
      tick();
      checks++;
      if (outs !== O_RUN) begin errors++; $display("FAIL rst_wait_run2: got %b want %b", outs, O_RUN); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_gating();
      test_branch_priority();
      test_mem_wait();
      test_back_to_back();
      test_lu3_freeze();
      test_saturation();
      test_reset_midwait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
